// File: rtl/udp_tx_framer_pkg.sv
// Shared types and constants for the UDP transmit framer.
package udp_tx_framer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StGrant,
      StHeader,
      StPayload,
      StGap
   } udp_state_e;

   localparam logic [15:0] UDP_HDR_LEN     = 16'd8;
   localparam logic [15:0] DEF_BASE_PORT   = 16'd1024;
   localparam logic [15:0] DEF_MAX_PAYLOAD = 16'd1472;

   // Header byte positions on the wire.
   localparam logic [2:0] HDR_SRC_MSB  = 3'd0;
   localparam logic [2:0] HDR_SRC_LSB  = 3'd1;
   localparam logic [2:0] HDR_DST_MSB  = 3'd2;
   localparam logic [2:0] HDR_DST_LSB  = 3'd3;
   localparam logic [2:0] HDR_LEN_MSB  = 3'd4;
   localparam logic [2:0] HDR_LEN_LSB  = 3'd5;
   localparam logic [2:0] HDR_CSUM_MSB = 3'd6;
   localparam logic [2:0] HDR_CSUM_LSB = 3'd7;

endpackage

// File: rtl/udp_tx_framer_hdr_mux.sv
// Combinational UDP header byte select.
module udp_hdr_mux
   import udp_tx_framer_pkg::*;
(
   input  logic [15:0] src_port_i,
   input  logic [15:0] dst_port_i,
   input  logic [15:0] udp_len_i,
   input  logic [2:0]  hdr_idx_i,
   output logic [7:0]  hdr_byte_o
);

   // Pick the header byte for the current index; checksum is sent as zero.
   always_comb begin
      hdr_byte_o = 8'h00;
      unique case (hdr_idx_i)
         HDR_SRC_MSB:  hdr_byte_o = src_port_i[15:8];
         HDR_SRC_LSB:  hdr_byte_o = src_port_i[7:0];
         HDR_DST_MSB:  hdr_byte_o = dst_port_i[15:8];
         HDR_DST_LSB:  hdr_byte_o = dst_port_i[7:0];
         HDR_LEN_MSB:  hdr_byte_o = udp_len_i[15:8];
         HDR_LEN_LSB:  hdr_byte_o = udp_len_i[7:0];
         HDR_CSUM_MSB: hdr_byte_o = 8'h00;
         HDR_CSUM_LSB: hdr_byte_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/udp_tx_framer.sv
// UDP transmit framer: grants the payload source, emits the 8-byte UDP header,
// streams the payload through, then holds a two-cycle inter-packet gap.
module udp_tx_framer
   import udp_tx_framer_pkg::*;
#(
   parameter logic [15:0] BASE_PORT   = DEF_BASE_PORT,
   parameter logic [15:0] MAX_PAYLOAD = DEF_MAX_PAYLOAD
) (
   input  logic        tx_clock,
   input  logic        reset_n,
   input  logic        udp_tx_request,
   input  logic [15:0] udp_tx_length,
   input  logic [7:0]  port_ID,
   input  logic [7:0]  udp_tx_data,
   input  logic [15:0] to_port,
   input  logic        ip_tx_ready,
   output logic        udp_tx_enable,
   output logic        udp_tx_active,
   output logic        ip_tx_start,
   output logic [15:0] ip_tx_length,
   output logic [7:0]  ip_tx_data,
   output logic        ip_tx_valid,
   output logic        len_err
);

   udp_state_e  state_q, state_d;
   logic [2:0]  hdr_idx_q, hdr_idx_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic        gap_cnt_q, gap_cnt_d;
   logic [15:0] len_q, len_d;
   logic [15:0] src_port_q, src_port_d;
   logic [15:0] dst_port_q, dst_port_d;
   logic [15:0] udp_len_q, udp_len_d;
   logic        len_err_q, len_err_d;
   logic        enable_q, enable_d;
   logic        start_q, start_d;
   logic        active_q, active_d;
   logic        valid_q, valid_d;
   logic [7:0]  hdr_byte;

   udp_hdr_mux u_hdr_mux (
      .src_port_i (src_port_q),
      .dst_port_i (dst_port_q),
      .udp_len_i  (udp_len_q),
      .hdr_idx_i  (hdr_idx_q),
      .hdr_byte_o (hdr_byte)
   );

   // Next-state, latches, counters and registered output flags.
   always_comb begin
      state_d    = state_q;
      hdr_idx_d  = hdr_idx_q;
      byte_cnt_d = byte_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      len_d      = len_q;
      src_port_d = src_port_q;
      dst_port_d = dst_port_q;
      udp_len_d  = udp_len_q;
      len_err_d  = len_err_q;
      unique case (state_q)
         StIdle: begin
            if (udp_tx_request && ip_tx_ready) begin
               state_d    = StGrant;
               len_d      = udp_tx_length;
               src_port_d = BASE_PORT + {8'd0, port_ID};
               dst_port_d = to_port;
               udp_len_d  = udp_tx_length + UDP_HDR_LEN;
               // Flag is visible in the grant cycle; the packet is still sent.
               if (udp_tx_length > MAX_PAYLOAD) len_err_d = 1'b1;
            end
         end
         StGrant: begin
            state_d    = StHeader;
            hdr_idx_d  = HDR_SRC_MSB;
            byte_cnt_d = 16'd0;
         end
         StHeader: begin
            if (hdr_idx_q == HDR_CSUM_LSB) begin
               state_d   = (len_q != 16'd0) ? StPayload : StGap;
               gap_cnt_d = 1'b0;
            end else begin
               hdr_idx_d = hdr_idx_q + 3'd1;
            end
         end
         StPayload: begin
            byte_cnt_d = byte_cnt_q + 16'd1;
            if (byte_cnt_q == len_q - 16'd1) begin
               state_d   = StGap;
               gap_cnt_d = 1'b0;
            end
         end
         StGap: begin
            if (gap_cnt_q) state_d = StIdle;
            else gap_cnt_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase
      enable_d = (state_d == StGrant);
      start_d  = (state_d == StGrant);
      active_d = (state_d == StPayload);
      valid_d  = (state_d == StHeader) || (state_d == StPayload);
   end

   // State and output registers; reset aborts any packet immediately.
   always_ff @(posedge tx_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         hdr_idx_q  <= 3'd0;
         byte_cnt_q <= 16'd0;
         gap_cnt_q  <= 1'b0;
         len_q      <= 16'd0;
         src_port_q <= 16'd0;
         dst_port_q <= 16'd0;
         udp_len_q  <= 16'd0;
         len_err_q  <= 1'b0;
         enable_q   <= 1'b0;
         start_q    <= 1'b0;
         active_q   <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hdr_idx_q  <= hdr_idx_d;
         byte_cnt_q <= byte_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         len_q      <= len_d;
         src_port_q <= src_port_d;
         dst_port_q <= dst_port_d;
         udp_len_q  <= udp_len_d;
         len_err_q  <= len_err_d;
         enable_q   <= enable_d;
         start_q    <= start_d;
         active_q   <= active_d;
         valid_q    <= valid_d;
      end
   end

   // Payload passes straight through in the cycle the byte is consumed.
   always_comb begin
      ip_tx_data = 8'h00;
      if (active_q) ip_tx_data = udp_tx_data;
      else if (valid_q) ip_tx_data = hdr_byte;
   end

   assign udp_tx_enable = enable_q;
   assign ip_tx_start   = start_q;
   assign udp_tx_active = active_q;
   assign ip_tx_valid   = valid_q;
   assign ip_tx_length  = udp_len_q;
   assign len_err       = len_err_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed testbench for udp_tx_framer with a byte-level scoreboard.
module tb_udp_tx_framer;

   localparam logic [15:0] TbBasePort   = 16'd1024;
   localparam logic [15:0] TbMaxPayload = 16'd1472;

   logic        tx_clock = 1'b0;
   logic        reset_n;
   logic        udp_tx_request;
   logic [15:0] udp_tx_length;
   logic [7:0]  port_ID;
   logic [7:0]  udp_tx_data;
   logic [15:0] to_port;
   logic        ip_tx_ready;
   logic        udp_tx_enable;
   logic        udp_tx_active;
   logic        ip_tx_start;
   logic [15:0] ip_tx_length;
   logic [7:0]  ip_tx_data;
   logic        ip_tx_valid;
   logic        len_err;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] sb[$];

   int seed = 0;
   int pay_idx;
   int n_active = 0;
   int n_enable = 0;
   int last_active = 0;
   int last_gap = 0;
   int inactive_run = 0;

   udp_tx_framer #(
      .BASE_PORT   (TbBasePort),
      .MAX_PAYLOAD (TbMaxPayload)
   ) dut (
      .tx_clock       (tx_clock),
      .reset_n        (reset_n),
      .udp_tx_request (udp_tx_request),
      .udp_tx_length  (udp_tx_length),
      .port_ID        (port_ID),
      .udp_tx_data    (udp_tx_data),
      .to_port        (to_port),
      .ip_tx_ready    (ip_tx_ready),
      .udp_tx_enable  (udp_tx_enable),
      .udp_tx_active  (udp_tx_active),
      .ip_tx_start    (ip_tx_start),
      .ip_tx_length   (ip_tx_length),
      .ip_tx_data     (ip_tx_data),
      .ip_tx_valid    (ip_tx_valid),
      .len_err        (len_err)
   );

   always #5 tx_clock = ~tx_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Payload source: byte k is a function of k, advanced on each consumed byte.
   always @(posedge tx_clock or negedge reset_n) begin
      if (!reset_n) pay_idx <= 0;
      else if (udp_tx_enable) pay_idx <= 0;
      else if (udp_tx_active) pay_idx <= pay_idx + 1;
   end
   assign udp_tx_data = 8'(pay_idx * 7 + seed);

   // Output monitor: scoreboard pops, idle-data and exclusivity checks, event counters.
   always @(negedge tx_clock) begin
      if (reset_n) begin
         if (ip_tx_valid) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("stream_byte", 32'(ip_tx_data), 32'(sb.pop_front()));
         end else begin
            check("idle_data_zero", 32'(ip_tx_data), 32'd0);
         end
         check("enable_vs_active", 32'(udp_tx_enable & udp_tx_active), 32'd0);
         if (udp_tx_enable) begin
            n_enable     <= n_enable + 1;
            last_active  <= n_active;
            last_gap     <= inactive_run;
            n_active     <= 0;
            inactive_run <= 0;
         end else if (udp_tx_active) begin
            n_active     <= n_active + 1;
            inactive_run <= 0;
         end else if (!ip_tx_valid) begin
            inactive_run <= inactive_run + 1;
         end
      end
   end

   task automatic tick();
      @(negedge tx_clock);
      #1;
   endtask

   task automatic push_packet(input logic [7:0] pid, input logic [15:0] tp,
                              input logic [15:0] len, input int sd);
      logic [15:0] src;
      logic [15:0] ulen;
      src  = TbBasePort + {8'd0, pid};
      ulen = len + 16'd8;
      sb.push_back(src[15:8]);
      sb.push_back(src[7:0]);
      sb.push_back(tp[15:8]);
      sb.push_back(tp[7:0]);
      sb.push_back(ulen[15:8]);
      sb.push_back(ulen[7:0]);
      sb.push_back(8'h00);
      sb.push_back(8'h00);
      for (int k = 0; k < int'(len); k++) sb.push_back(8'(k * 7 + sd));
   endtask

   task automatic wait_enable(input logic [15:0] len, input logic exp_err);
      for (int i = 0; i < 200; i++) begin
         tick();
         if (udp_tx_enable) break;
      end
      check("grant_enable", 32'(udp_tx_enable), 32'd1);
      check("grant_start", 32'(ip_tx_start), 32'd1);
      check("grant_length", 32'(ip_tx_length), 32'(len + 16'd8));
      check("grant_len_err", 32'(len_err), 32'(exp_err));
   endtask

   task automatic wait_done(input logic [15:0] len);
      for (int i = 0; i < int'(len) + 100; i++) begin
         tick();
         if (sb.size() == 0 && !ip_tx_valid) break;
      end
      check("sb_drained", 32'(sb.size()), 32'd0);
      repeat (3) tick();
      check("active_count", 32'(n_active), 32'(len));
   endtask

   task automatic send(input logic [7:0] pid, input logic [15:0] tp, input logic [15:0] len,
                       input int sd, input logic exp_err);
      int en0;
      en0 = n_enable;
      push_packet(pid, tp, len, sd);
      seed           = sd;
      port_ID        = pid;
      to_port        = tp;
      udp_tx_length  = len;
      udp_tx_request = 1'b1;
      wait_enable(len, exp_err);
      // Inputs disturbed after grant must not affect the packet.
      udp_tx_request = 1'b0;
      udp_tx_length  = 16'hBEEF;
      port_ID        = 8'h5A;
      to_port        = 16'h1234;
      wait_done(len);
      check("one_enable", 32'(n_enable), 32'(en0 + 1));
   endtask

   initial begin
      int en0;
      reset_n        = 1'b0;
      udp_tx_request = 1'b0;
      udp_tx_length  = 16'd0;
      port_ID        = 8'd0;
      to_port        = 16'd0;
      ip_tx_ready    = 1'b1;
      #3;
      check("rst_enable", 32'(udp_tx_enable), 32'd0);
      check("rst_active", 32'(udp_tx_active), 32'd0);
      check("rst_start", 32'(ip_tx_start), 32'd0);
      check("rst_valid", 32'(ip_tx_valid), 32'd0);
      check("rst_data", 32'(ip_tx_data), 32'd0);
      check("rst_length", 32'(ip_tx_length), 32'd0);
      check("rst_len_err", 32'(len_err), 32'd0);
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (2) tick();

      // Header 04 0B 04 0B 05 AC 00 00, 1444 payload bytes.
      send(8'd11, 16'd1035, 16'd1444, 3, 1'b0);

      // Zero-length packet: header only.
      send(8'd2, 16'd80, 16'd0, 0, 1'b0);

      // Request held while downstream not ready.
      en0 = n_enable;
      push_packet(8'd5, 16'd2000, 16'd16, 9);
      seed           = 9;
      port_ID        = 8'd5;
      to_port        = 16'd2000;
      udp_tx_length  = 16'd16;
      ip_tx_ready    = 1'b0;
      udp_tx_request = 1'b1;
      repeat (50) tick();
      check("no_grant_not_ready", 32'(n_enable), 32'(en0));
      ip_tx_ready = 1'b1;
      tick();
      check("grant_first_ready", 32'(udp_tx_enable), 32'd1);
      udp_tx_request = 1'b0;
      wait_done(16'd16);

      // Back-to-back with the request held: two GAP cycles plus the IDLE sampling cycle.
      en0 = n_enable;
      push_packet(8'd20, 16'd3000, 16'd64, 21);
      push_packet(8'd20, 16'd3000, 16'd64, 21);
      seed           = 21;
      port_ID        = 8'd20;
      to_port        = 16'd3000;
      udp_tx_length  = 16'd64;
      udp_tx_request = 1'b1;
      wait_enable(16'd64, 1'b0);
      for (int i = 0; i < 200; i++) begin
         tick();
         if (udp_tx_enable) break;
      end
      udp_tx_request = 1'b0;
      check("b2b_second_grant", 32'(n_enable), 32'(en0 + 2));
      check("b2b_first_active", 32'(last_active), 32'd64);
      check("b2b_gap", 32'(last_gap), 32'd3);
      wait_done(16'd64);

      // Oversize payload: error flagged at grant and sticky, packet still complete.
      send(8'd1, 16'd500, 16'd1500, 5, 1'b1);
      check("len_err_sticky", 32'(len_err), 32'd1);

      // Asynchronous reset in the middle of the payload.
      push_packet(8'd7, 16'd600, 16'd300, 13);
      seed           = 13;
      port_ID        = 8'd7;
      to_port        = 16'd600;
      udp_tx_length  = 16'd300;
      udp_tx_request = 1'b1;
      wait_enable(16'd300, 1'b1);
      udp_tx_request = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (n_active == 100) break;
         tick();
      end
      check("reached_byte_100", 32'(n_active), 32'd100);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_enable", 32'(udp_tx_enable), 32'd0);
      check("arst_active", 32'(udp_tx_active), 32'd0);
      check("arst_start", 32'(ip_tx_start), 32'd0);
      check("arst_valid", 32'(ip_tx_valid), 32'd0);
      check("arst_data", 32'(ip_tx_data), 32'd0);
      check("arst_length", 32'(ip_tx_length), 32'd0);
      check("arst_len_err", 32'(len_err), 32'd0);
      sb.delete();
      repeat (3) tick();
      reset_n = 1'b1;
      en0 = n_enable;
      repeat (5) tick();
      check("idle_after_reset", 32'(n_enable), 32'(en0));
      send(8'd9, 16'd700, 16'd40, 17, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/udp_tx_framer.md
UDP_TX_FRAMER -- requirements
Module: udp_tx_framer

Interface
REQ-001 Parameter BASE_PORT, default 16'd1024: base UDP source port; source port = BASE_PORT + port_ID.
REQ-002 Parameter MAX_PAYLOAD, default 16'd1472: largest legal UDP payload in bytes.
REQ-003 One clock, reset asynchronous active-low: tx_clock in 1 (all logic on its rising edge); reset_n in 1 (async assert, active low).
REQ-004 udp_tx_request in 1: payload source wants to send a packet.
REQ-005 udp_tx_length in 16: payload byte count, stable while udp_tx_request is high.
REQ-006 port_ID in 8: source-port offset, stable while udp_tx_request is high.
REQ-007 udp_tx_data in 8: payload byte; byte 0 valid the cycle after udp_tx_enable, byte k+1 the cycle after the k-th active cycle.
REQ-008 to_port in 16: destination UDP port (PC port), sampled at grant.
REQ-009 ip_tx_ready in 1: downstream IP/MAC layer idle and able to start a datagram.
REQ-010 udp_tx_enable out 1: one-cycle grant to the payload source.
REQ-011 udp_tx_active out 1: high exactly once per payload byte consumed.
REQ-012 ip_tx_start out 1: one-cycle pulse, datagram begins next cycle.
REQ-013 ip_tx_length out 16: UDP length (payload + 8), valid from ip_tx_start to end of packet.
REQ-014 ip_tx_data out 8 and ip_tx_valid out 1: UDP byte stream, one byte per valid cycle, no back-pressure.
REQ-015 len_err out 1: sticky flag, payload length exceeded MAX_PAYLOAD.

Function
REQ-016 States: IDLE, GRANT, HEADER, PAYLOAD, GAP.
REQ-017 IDLE: when udp_tx_request and ip_tx_ready are both high, latch udp_tx_length, port_ID and to_port, and go to GRANT; otherwise stay.
REQ-018 GRANT (1 cycle): udp_tx_enable=1 and ip_tx_start=1, then go to HEADER with header index 0.
REQ-019 HEADER (8 cycles): ip_tx_valid=1; bytes in order: src port MSB, src port LSB, dst port MSB, dst port LSB, length MSB, length LSB, 0x00, 0x00 (checksum disabled).
REQ-020 Length arithmetic is 16-bit unsigned payload+8; the source port addition wraps modulo 2^16.
REQ-021 After header byte 7, go to PAYLOAD if the latched length is nonzero, otherwise go to GAP.
REQ-022 PAYLOAD: udp_tx_active=1 and ip_tx_valid=1 every cycle, ip_tx_data=udp_tx_data in the same cycle, and a 16-bit counter increments.
REQ-023 PAYLOAD exit: after exactly the latched-length active cycles, go to GAP; there are no idle cycles inside a packet.
REQ-024 GAP: hold all outputs inactive for 2 cycles, then return to IDLE; a request held through GAP is granted no earlier than the cycle after IDLE is re-entered.
REQ-025 A latched length above MAX_PAYLOAD sets len_err at GRANT, and the packet is still sent in full so the source never stalls; only reset clears len_err.
REQ-026 Input changes after grant (request drop, length/port change) are ignored until IDLE.
REQ-027 ip_tx_ready is sampled only in IDLE; deassertion mid-packet has no effect.
REQ-028 udp_tx_enable and ip_tx_start are never high in the same cycle as udp_tx_active.
REQ-029 ip_tx_data is 0x00 whenever ip_tx_valid is low.

Reset
REQ-030 While reset_n is low: state IDLE, all outputs 0 (udp_tx_enable, udp_tx_active, ip_tx_start, ip_tx_valid, ip_tx_data, ip_tx_length, len_err), counters and latches 0.
REQ-031 Reset asserted mid-packet aborts immediately with no partial completion; after release the block waits in IDLE for a fresh request.

Structure
REQ-032 A shared package holds: the state enumeration, UDP_HDR_LEN=8, the default BASE_PORT and MAX_PAYLOAD, and the header byte-index constants.
REQ-033 One sub-module, udp_hdr_mux: a combinational 8-to-1 header byte select from latched ports, length and index; the FSM and counters stay in udp_tx_framer.

Verification
REQ-034 Scenario: port_ID=11, to_port=1035, length=1444, ip_tx_ready=1 -> one enable pulse, header 04 0B 04 0B 05 AC 00 00, then 1444 active cycles with ip_tx_data matching source bytes, then GAP.
REQ-035 Scenario: length=0, port_ID=2 -> header ends 00 08 00 00, no udp_tx_active, return to IDLE after GAP.
REQ-036 Scenario: request held with ip_tx_ready=0 for 50 cycles, then 1 -> no enable during wait; grant on the first cycle ready is seen in IDLE.
REQ-037 Scenario: back-to-back requests (length 64, then 64) -> exactly 2 idle GAP cycles between packets, each packet with exactly 64 active cycles.
REQ-038 Scenario: length=1500 -> len_err=1 at grant, all 1500 bytes streamed, len_err still 1 after packet.
REQ-039 Scenario: reset_n low at payload byte 100 -> all outputs 0 asynchronously; next request after release produces a complete, correct packet.
